dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-port, input-registered data memory.
- The memory latches its address and write data on every clock edge. It applies the write enable one cycle later against the latched address. Read data is valid combinationally in that same cycle.
- This block shares the memory between requester 0 (core load/store path) and requester 1 (aux/DMA/debug). It arbitrates round-robin and generates the correctly timed write enable.
- It returns read data with a registered valid pulse.

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port, input-registered data memory.
// Each transaction is one IDLE grant cycle followed by one ACCESS cycle.
module dmem_arbiter #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int DMEMADDRBITS   = 13,
    parameter int DMEMWORDBITS   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0,
    input  logic                      req1,
    input  logic                      we0,
    input  logic                      we1,
    input  logic [DATA_BIT_WIDTH-1:0] addr0,
    input  logic [DATA_BIT_WIDTH-1:0] addr1,
    input  logic [DATA_BIT_WIDTH-1:0] wdata0,
    input  logic [DATA_BIT_WIDTH-1:0] wdata1,
    output logic                      gnt0,
    output logic                      gnt1,
    output logic                      rvalid0,
    output logic                      rvalid1,
    output logic                      err0,
    output logic                      err1,
    output logic [DATA_BIT_WIDTH-1:0] rdata,
    output logic                      busy,
    output logic [DATA_BIT_WIDTH-1:0] memAddr,
    output logic [DATA_BIT_WIDTH-1:0] memDataIn,
    output logic                      memWrEn,
    input  logic [DATA_BIT_WIDTH-1:0] memRegOut
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state, state_nxt;
    logic   ptr, ptr_nxt;
    logic   owner, owner_nxt;
    logic   we_q, we_nxt;
    logic   er_q, er_nxt;
    logic   sel;
    logic   grant;

    logic [1:0][DATA_BIT_WIDTH-1:0] addr_v;
    logic [1:0][DATA_BIT_WIDTH-1:0] wdata_v;
    logic [1:0]                     we_v;

    // The byte offset must sit inside the decoded window; an impossible split elaborates nothing.
    if (DMEMWORDBITS >= DMEMADDRBITS) begin : g_bad_word_bits
    end

    assign addr_v  = {addr1, addr0};
    assign wdata_v = {wdata1, wdata0};
    assign we_v    = {we1, we0};

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        we_nxt    = we_q;
        er_nxt    = er_q;
        sel       = 1'b0;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    sel     = ptr;
                    ptr_nxt = ~ptr;
                    grant   = 1'b1;
                end else if (req0) begin
                    sel   = 1'b0;
                    grant = 1'b1;
                end else if (req1) begin
                    sel   = 1'b1;
                    grant = 1'b1;
                end
                if (grant) begin
                    state_nxt = ACCESS;
                    owner_nxt = sel;
                    we_nxt    = we_v[sel];
                    er_nxt    = |addr_v[sel][DATA_BIT_WIDTH-1:DMEMADDRBITS];
                end
            end
            ACCESS: begin
                sel       = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address and data go out combinationally so the memory latches the winner at the grant edge.
    assign memAddr   = addr_v[sel];
    assign memDataIn = wdata_v[sel];
    assign gnt0      = grant & ~sel & ~reset;
    assign gnt1      = grant & sel & ~reset;
    assign busy      = (state == ACCESS);
    assign memWrEn   = (state == ACCESS) & we_q & ~er_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            er_q    <= 1'b0;
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner   <= owner_nxt;
            we_q    <= we_nxt;
            er_q    <= er_nxt;
            rvalid0 <= (state == ACCESS) & ~we_q & ~owner;
            rvalid1 <= (state == ACCESS) & ~we_q & owner;
            err0    <= (state == ACCESS) & er_q & ~owner;
            err1    <= (state == ACCESS) & er_q & owner;
            if (state == ACCESS && !we_q)
                rdata <= er_q ? '0 : memRegOut;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural input-registered memory behind it.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, busy, memWrEn;
    logic [31:0] rdata, memAddr, memDataIn, memRegOut;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.DATA_BIT_WIDTH(32), .DMEMADDRBITS(13), .DMEMWORDBITS(2)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .err0(err0), .err1(err1), .rdata(rdata), .busy(busy),
        .memAddr(memAddr), .memDataIn(memDataIn), .memWrEn(memWrEn),
        .memRegOut(memRegOut)
    );

    always #5 clk = ~clk;

    // Memory: latches address/data every edge, writes one cycle later at the latched address.
    logic [31:0] mem [0:2047];
    logic [31:0] ma_q, md_q;
    always @(posedge clk) begin
        ma_q <= memAddr;
        md_q <= memDataIn;
        if (memWrEn) mem[ma_q[12:2]] <= md_q;
    end
    assign memRegOut = mem[ma_q[12:2]];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in an IDLE cycle, reports the grants seen, and drops req after the edge.
    task automatic issue(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic g0, output logic g1);
        if (r) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        @(negedge clk);
        g0 = gnt0;
        g1 = gnt1;
        next_cycle();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 32'h55; addr1 = 32'h99; wdata0 = 32'h0A0A0A0A; wdata1 = 32'h0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b%b exp=00", gnt1, gnt0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (memWrEn !== 1'b0) begin bad++; $display("FAIL rst_wren got=%b exp=0", memWrEn); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        total++; if ({rvalid1, rvalid0, err1, err0} !== 4'b0) begin bad++; $display("FAIL rst_pulses got=%b exp=0000", {rvalid1, rvalid0, err1, err0}); end
        total++; if (memAddr !== 32'h55 || memDataIn !== 32'h0A0A0A0A) begin bad++; $display("FAIL rst_mux got=%h/%h exp=55/0a0a0a0a", memAddr, memDataIn); end
        next_cycle();
    endtask

    task automatic test_write_read();
        logic g0, g1;
        issue(0, 1, 32'h10, 32'hDEADBEEF, g0, g1);
        total++; if ({g1, g0} !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b%b exp=01", g1, g0); end
        @(negedge clk);
        total++; if (memWrEn !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL wr_access wren=%b busy=%b exp=1/1", memWrEn, busy); end
        total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL wr_nognt got=%b exp=0", gnt0); end
        next_cycle();
        @(negedge clk);
        total++; if (memWrEn !== 1'b0 || rvalid0 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL wr_done wren=%b rv=%b err=%b exp=000", memWrEn, rvalid0, err0); end
        next_cycle();
        issue(0, 0, 32'h10, 32'h0, g0, g1);
        total++; if (g0 !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%b exp=1", g0); end
        @(negedge clk);
        total++; if (rvalid0 !== 1'b0 || memWrEn !== 1'b0) begin bad++; $display("FAIL rd_access rv=%b wren=%b exp=0/0", rvalid0, memWrEn); end
        next_cycle();
        @(negedge clk);
        total++; if (rvalid0 !== 1'b1 || rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data rv=%b rdata=%h exp=1/deadbeef", rvalid0, rdata); end
        next_cycle();
        @(negedge clk);
        total++; if (rvalid0 !== 1'b0) begin bad++; $display("FAIL rd_pulse_width got=%b exp=0", rvalid0); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [9:0] eg0 = 10'b0001010001 & 10'b0000010001;
        logic [9:0] eg1 = 10'b0001000100;
        logic [9:0] erv0 = 10'b0001000100;
        logic [9:0] erv1 = 10'b0100010000;
        req0 = 1; we0 = 0; addr0 = 32'h0;
        req1 = 1; we1 = 0; addr1 = 32'h4;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) begin req0 = 0; req1 = 0; end
            @(negedge clk);
            total++;
            if ({gnt1, gnt0, rvalid1, rvalid0} !== {eg1[k], eg0[k], erv1[k], erv0[k]}) begin
                bad++;
                $display("FAIL rr_cycle%0d got g1g0=%b%b rv1rv0=%b%b exp g1g0=%b%b rv1rv0=%b%b",
                         k, gnt1, gnt0, rvalid1, rvalid0, eg1[k], eg0[k], erv1[k], erv0[k]);
            end
            next_cycle();
        end
    endtask

    task automatic test_cross_write_read();
        logic g0, g1;
        issue(1, 1, 32'h20, 32'h12345678, g0, g1);
        total++; if ({g1, g0} !== 2'b10) begin bad++; $display("FAIL xw_gnt got=%b%b exp=10", g1, g0); end
        req0 = 1; we0 = 0; addr0 = 32'h20;
        @(negedge clk);
        total++; if (gnt0 !== 1'b0 || memWrEn !== 1'b1) begin bad++; $display("FAIL xw_access gnt0=%b wren=%b exp=0/1", gnt0, memWrEn); end
        next_cycle();
        @(negedge clk);
        total++; if (gnt0 !== 1'b1 || rvalid1 !== 1'b0 || err1 !== 1'b0) begin bad++; $display("FAIL xr_gnt gnt0=%b rv1=%b err1=%b exp=1/0/0", gnt0, rvalid1, err1); end
        next_cycle();
        req0 = 0;
        next_cycle();
        @(negedge clk);
        total++; if (rvalid0 !== 1'b1 || rdata !== 32'h12345678) begin bad++; $display("FAIL xr_data rv=%b rdata=%h exp=1/12345678", rvalid0, rdata); end
        next_cycle();
    endtask

    task automatic test_window_error();
        logic g0, g1;
        issue(0, 1, 32'h0, 32'hCAFEF00D, g0, g1);
        next_cycle();
        next_cycle();
        issue(0, 1, 32'h00002000, 32'hBAD0BAD0, g0, g1);
        total++; if (g0 !== 1'b1) begin bad++; $display("FAIL errw_gnt got=%b exp=1", g0); end
        @(negedge clk);
        total++; if (memWrEn !== 1'b0) begin bad++; $display("FAIL errw_wren got=%b exp=0", memWrEn); end
        next_cycle();
        @(negedge clk);
        total++; if (err0 !== 1'b1 || rvalid0 !== 1'b0) begin bad++; $display("FAIL errw_pulse err=%b rv=%b exp=1/0", err0, rvalid0); end
        next_cycle();
        issue(0, 0, 32'h0, 32'h0, g0, g1);
        next_cycle();
        @(negedge clk);
        total++; if (rvalid0 !== 1'b1 || err0 !== 1'b0 || rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL err_prior rv=%b err=%b rdata=%h exp=1/0/cafef00d", rvalid0, err0, rdata); end
        next_cycle();
        issue(0, 0, 32'h00004000, 32'h0, g0, g1);
        next_cycle();
        @(negedge clk);
        total++; if (rvalid0 !== 1'b1 || err0 !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL errr rv=%b err=%b rdata=%h exp=1/1/0", rvalid0, err0, rdata); end
        next_cycle();
    endtask

    task automatic test_reset_in_access();
        logic g0, g1;
        issue(0, 1, 32'h30, 32'h11111111, g0, g1);
        next_cycle();
        next_cycle();
        issue(0, 1, 32'h30, 32'h22222222, g0, g1);
        reset = 1'b1;
        @(negedge clk);
        total++; if (memWrEn !== 1'b0) begin bad++; $display("FAIL rsta_wren got=%b exp=0", memWrEn); end
        next_cycle();
        reset = 1'b0;
        req1 = 1; we1 = 0; addr1 = 32'h30;
        @(negedge clk);
        total++; if (gnt1 !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rsta_gnt1 gnt1=%b busy=%b exp=1/0", gnt1, busy); end
        total++; if (rvalid0 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL rsta_nopulse rv=%b err=%b exp=0/0", rvalid0, err0); end
        next_cycle();
        req1 = 0;
        next_cycle();
        @(negedge clk);
        total++; if (rvalid1 !== 1'b1 || rdata !== 32'h11111111) begin bad++; $display("FAIL rsta_word rv1=%b rdata=%h exp=1/11111111", rvalid1, rdata); end
        next_cycle();
    endtask

    task automatic test_byte_offset();
        logic g0, g1;
        req1 = 1; we1 = 1; addr1 = 32'h13; wdata1 = 32'hA5A55A5A;
        @(negedge clk);
        total++; if (gnt1 !== 1'b1 || memAddr !== 32'h13) begin bad++; $display("FAIL bo_addr gnt1=%b addr=%h exp=1/13", gnt1, memAddr); end
        next_cycle();
        req1 = 0;
        next_cycle();
        next_cycle();
        issue(1, 0, 32'h10, 32'h0, g0, g1);
        next_cycle();
        @(negedge clk);
        total++; if (rvalid1 !== 1'b1 || rdata !== 32'hA5A55A5A) begin bad++; $display("FAIL bo_read rv1=%b rdata=%h exp=1/a5a55a5a", rvalid1, rdata); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_cross_write_read();
        test_window_error();
        test_reset_in_access();
        test_byte_offset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
